rbzero_spi_tx: RTL and testbench

SPI-mode-0 transmitter (master) that drives the raybox-zero SPI slave ports (vector port `i_vec_*` and register port `i_reg_*`) from on-chip logic. A frame of up to DATA_W bits, MSB-first, is accepted through a start/ready handshake and shifted out on csb/sclk/mosi with a programmable half-period, so a demo sequencer or LA-side controller can update view vectors and registers without bit-banging. One instance is used per slave port.

---
 rtl/rbzero_spi_tx.sv | 141 ++++++++++++++
 tb/tb_rbzero_spi_tx.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rbzero_spi_tx.sv
// SPI mode-0 master: shifts an MSB-first frame of 1..DATA_W bits out on csb/sclk/mosi.
// Latency: first mosi bit and csb fall one cycle after i_start is accepted; o_done at T+1+HALF*(2*len+2).
// Backpressure: o_ready low for the whole frame; i_start is ignored while o_busy=1.
//
// Ports:
//   clk, reset_n       - design clock, synchronous active-low reset
//   i_start/o_ready    - frame request handshake; i_data (MSB-aligned) and i_len latched on accept
//   o_busy, o_done     - frame in progress; one-cycle completion pulse in the first idle cycle
//   o_csb/o_sclk/o_mosi - SPI pins, all registered; sclk idles low
module rbzero_spi_tx #(
    parameter int DATA_W = 80,
    parameter int HALF   = 2,
    parameter int LEN_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_data,
    input  logic [LEN_W-1:0]  i_len,
    output logic              o_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_csb,
    output logic              o_sclk,
    output logic              o_mosi
);

    localparam int               HC_W    = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [HC_W-1:0]  HC_LAST = HC_W'(HALF - 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD,
        S_GAP
    } state_t;

    state_t            state, state_nxt;
    logic [HC_W-1:0]   hcnt, hcnt_nxt;
    logic [LEN_W-1:0]  bits, bits_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic              half_done;
    logic              in_frame;
    logic              done_nxt;
    logic              csb_nxt;
    logic              sclk_nxt;
    logic              mosi_nxt;

    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt;
        bits_nxt  = bits;
        shreg_nxt = shreg;
        done_nxt  = 1'b0;
        half_done = (hcnt == HC_LAST);

        // Every non-idle state lasts exactly HALF cycles.
        if (state != S_IDLE) begin
            hcnt_nxt = half_done ? '0 : hcnt + 1'b1;
        end

        unique case (state)
            S_IDLE: begin
                // A zero-length request is dropped without any pin activity.
                if (i_start && (i_len != '0)) begin
                    state_nxt = S_SETUP;
                    hcnt_nxt  = '0;
                    shreg_nxt = i_data;
                    bits_nxt  = (i_len > LEN_MAX) ? LEN_MAX : i_len;
                end
            end
            S_SETUP: begin
                if (half_done) state_nxt = S_HIGH;
            end
            S_HIGH: begin
                if (half_done) begin
                    bits_nxt = bits - 1'b1;
                    if (bits == LEN_W'(1)) begin
                        // Last bit stays on mosi through HOLD.
                        state_nxt = S_HOLD;
                    end else begin
                        state_nxt = S_LOW;
                        shreg_nxt = {shreg[DATA_W-2:0], 1'b0};
                    end
                end
            end
            S_LOW: begin
                if (half_done) state_nxt = S_HIGH;
            end
            S_HOLD: begin
                if (half_done) state_nxt = S_GAP;
            end
            S_GAP: begin
                if (half_done) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Pins are registered from the next state so they line up with it exactly.
        in_frame = (state_nxt == S_SETUP) || (state_nxt == S_HIGH) ||
                   (state_nxt == S_LOW)   || (state_nxt == S_HOLD);
        csb_nxt  = ~in_frame;
        sclk_nxt = (state_nxt == S_HIGH);
        mosi_nxt = in_frame & shreg_nxt[DATA_W-1];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            hcnt    <= '0;
            bits    <= '0;
            shreg   <= '0;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_csb   <= 1'b1;
            o_sclk  <= 1'b0;
            o_mosi  <= 1'b0;
        end else begin
            state   <= state_nxt;
            hcnt    <= hcnt_nxt;
            bits    <= bits_nxt;
            shreg   <= shreg_nxt;
            o_ready <= (state_nxt == S_IDLE);
            o_busy  <= (state_nxt != S_IDLE);
            o_done  <= done_nxt;
            o_csb   <= csb_nxt;
            o_sclk  <= sclk_nxt;
            o_mosi  <= mosi_nxt;
        end
    end

endmodule

// File: tb/tb_rbzero_spi_tx.sv
// Bench for rbzero_spi_tx: two instances (HALF=2 and HALF=1) sharing one clock and reset.
// Stimulus pushes expected frames into a scoreboard; a slave-side monitor pops and checks them.
// Frame contents, edge counts and timing are predicted from the SPI rules with plain arithmetic.
module tb_rbzero_spi_tx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start [2];
    logic [79:0] data [2];
    logic [6:0]  len [2];
    logic [1:0]  ready, busy, done, csb, sclk, mosi;

    rbzero_spi_tx #(.DATA_W(80), .HALF(2)) u_dut_h2 (
        .clk(clk), .reset_n(reset_n), .i_start(start[0]), .i_data(data[0]), .i_len(len[0]),
        .o_ready(ready[0]), .o_busy(busy[0]), .o_done(done[0]),
        .o_csb(csb[0]), .o_sclk(sclk[0]), .o_mosi(mosi[0])
    );

    rbzero_spi_tx #(.DATA_W(80), .HALF(1)) u_dut_h1 (
        .clk(clk), .reset_n(reset_n), .i_start(start[1]), .i_data(data[1]), .i_len(len[1]),
        .o_ready(ready[1]), .o_busy(busy[1]), .o_done(done[1]),
        .o_csb(csb[1]), .o_sclk(sclk[1]), .o_mosi(mosi[1])
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic int half_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    // One expected frame: len is the number of sclk rises the slave should see.
    typedef struct {
        int          inst;
        logic [79:0] data;
        int          len;
        int          t;      // cycle in which i_start was presented and accepted
        bit          abort;  // frame is cut by reset: no done, no timing checks
        int          gap;    // required csb-high cycles before this frame (0 = unchecked)
    } exp_t;

    exp_t sb[$];

    // ---------------- slave-side monitor ----------------
    exp_t        cur [2];
    bit          active [2];
    bit          done_pend [2];
    int          done_exp [2];
    int          fall_cyc [2];
    int          rise_cyc [2];
    int          edges [2];
    int          frames [2];
    int          dones [2];
    logic [79:0] rx [2];
    logic [1:0]  csb_p = 2'b11;
    logic [1:0]  sclk_p = 2'b00;
    logic [1:0]  mosi_p = 2'b00;

    initial begin
        for (int i = 0; i < 2; i++) begin
            active[i] = 0; done_pend[i] = 0; done_exp[i] = 0; fall_cyc[i] = 0;
            rise_cyc[i] = 0; edges[i] = 0; frames[i] = 0; dones[i] = 0; rx[i] = '0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (sclk[i] && csb[i]) chk("sclk_high_with_csb_high", 1, 0);
            if (sclk_p[i] && sclk[i] && (mosi[i] != mosi_p[i])) chk("mosi_changed_while_sclk_high", 1, 0);

            if (csb_p[i] && !csb[i]) begin
                fall_cyc[i] = cyc;
                edges[i]    = 0;
                rx[i]       = '0;
                chk("frame_expected", (sb.size() > 0 && sb[0].inst == i), 1);
                if (sb.size() > 0 && sb[0].inst == i) begin
                    cur[i]    = sb.pop_front();
                    active[i] = 1;
                    chk("start_to_csb_latency", cyc, cur[i].t + 1);
                    if (cur[i].gap > 0) chk("csb_gap", cyc - rise_cyc[i], cur[i].gap);
                end
            end

            if (!sclk_p[i] && sclk[i] && !csb[i]) begin
                edges[i]++;
                rx[i] = {rx[i][78:0], mosi[i]};
            end

            if (!csb_p[i] && csb[i]) begin
                rise_cyc[i] = cyc;
                if (active[i]) begin
                    active[i] = 0;
                    frames[i]++;
                    chk("sclk_edges", edges[i], cur[i].len);
                    chk("rx_data", rx[i], cur[i].data >> (80 - cur[i].len));
                    if (!cur[i].abort) begin
                        chk("csb_low_cycles", cyc - fall_cyc[i], half_of(i) * (2 * cur[i].len + 1));
                        done_exp[i]  = cur[i].t + 1 + half_of(i) * (2 * cur[i].len + 2);
                        done_pend[i] = 1;
                    end
                end
            end

            if (done[i]) begin
                chk("done_time", done_pend[i] ? cyc : -1, done_exp[i]);
                chk("ready_with_done", ready[i], 1);
                done_pend[i] = 0;
                dones[i]++;
            end

            csb_p[i]  = csb[i];
            sclk_p[i] = sclk[i];
            mosi_p[i] = mosi[i];
        end
    end

    // ---------------- stimulus ----------------
    int ndone [2];

    task automatic send(input int i, input logic [79:0] d, input int l, input bit ab, input int ab_edges);
        exp_t e;
        bit   ok = 0;
        for (int k = 0; k < 2000 && !ok; k++) begin
            @(negedge clk);
            if (ready[i]) ok = 1;
        end
        chk("ready_wait", ok, 1);
        start[i] = 1'b1;
        data[i]  = d;
        len[i]   = 7'(l);
        if (l != 0) begin
            e.inst  = i;
            e.data  = d;
            e.len   = ab ? ab_edges : ((l > 80) ? 80 : l);
            e.t     = cyc;
            e.abort = ab;
            e.gap   = 0;
            sb.push_back(e);
            if (!ab) ndone[i]++;
        end
        @(negedge clk);
        start[i] = 1'b0;
        data[i]  = {$urandom, $urandom, $urandom};
        len[i]   = 7'($urandom);
    endtask

    task automatic wait_dones(input int i);
        bit ok = 0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            if (dones[i] >= ndone[i]) ok = 1;
            else @(negedge clk);
        end
        chk("done_wait", ok, 1);
    endtask

    task automatic chk_idle(input int i);
        chk("idle_csb", csb[i], 1);
        chk("idle_sclk", sclk[i], 0);
        chk("idle_mosi", mosi[i], 0);
        chk("idle_done", done[i], 0);
        chk("idle_ready", ready[i], 1);
        chk("idle_busy", busy[i], 0);
    endtask

    initial begin
        exp_t        e;
        int          n;
        int          f0;
        bit          ok;
        logic [79:0] rd;

        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; data[i] = '0; len[i] = '0; ndone[i] = 0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk_idle(0);
        chk_idle(1);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic byte, full 80-bit vector, single bit, oversize length
        send(0, {8'hA5, 72'h0}, 8, 0, 0);          wait_dones(0);
        send(0, 80'h0123_4567_89AB_CDEF_1357, 80, 0, 0); wait_dones(0);
        send(0, {1'b1, 79'h0}, 1, 0, 0);           wait_dones(0);
        rd = {$urandom, $urandom, $urandom};
        send(0, rd, 100, 0, 0);                    wait_dones(0);

        // Zero length: no pin activity and no done
        f0 = frames[0];
        send(0, {$urandom, $urandom, $urandom}, 0, 0, 0);
        repeat (40) @(negedge clk);
        chk("len0_frames", frames[0], f0);
        chk("len0_dones", dones[0], ndone[0]);
        chk("len0_ready", ready[0], 1);

        // i_start held high: back-to-back frames; csb high for GAP plus the done cycle
        @(negedge clk);
        start[0] = 1'b1;
        data[0]  = {4'b1011, 76'h0};
        len[0]   = 7'd4;
        n = 0;
        for (int k = 0; k < 600 && n < 4; k++) begin
            if (ready[0]) begin
                e.inst = 0; e.data = data[0]; e.len = 4; e.t = cyc; e.abort = 0;
                e.gap  = (n == 0) ? 0 : half_of(0) + 1;
                sb.push_back(e);
                ndone[0]++;
                n++;
            end
            @(negedge clk);
        end
        start[0] = 1'b0;
        chk("held_start_accepts", n, 4);
        wait_dones(0);

        // i_start pulsed mid-frame is ignored
        f0 = frames[0];
        send(0, {$urandom, $urandom, $urandom}, 40, 0, 0);
        repeat (20) @(negedge clk);
        chk("busy_ready_low", ready[0], 0);
        chk("busy_flag", busy[0], 1);
        start[0] = 1'b1;
        data[0]  = {$urandom, $urandom, $urandom};
        len[0]   = 7'd8;
        @(negedge clk);
        start[0] = 1'b0;
        wait_dones(0);
        repeat (20) @(negedge clk);
        chk("busy_frame_count", frames[0], f0 + 1);

        // Reset after three sclk rises
        send(0, {$urandom, $urandom, $urandom}, 8, 1, 3);
        ok = 0;
        for (int k = 0; k < 500 && !ok; k++) begin
            @(negedge clk);
            if (edges[0] >= 3 && !csb[0]) ok = 1;
        end
        chk("third_edge_wait", ok, 1);
        reset_n = 1'b0;
        @(negedge clk);
        chk_idle(0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_done_after_reset", dones[0], ndone[0]);
        send(0, {8'h3C, 72'h0}, 8, 0, 0);          wait_dones(0);

        // HALF=1 build
        send(1, {8'h5A, 72'h0}, 8, 0, 0);          wait_dones(1);

        // Random frames on both builds
        for (int r = 0; r < 10; r++) begin
            n = int'($urandom_range(0, 1));
            send(n, {$urandom, $urandom, $urandom}, int'($urandom_range(1, 80)), 0, 0);
            wait_dones(n);
        end

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
